// File: rtl/fnd_scan_ctrl_if.sv
// Frame-load channel into the FND scan controller: one full frame of segment
// and decimal-point data, transferred with a valid/ready handshake.
interface fnd_scan_ctrl_if #(
    parameter int unsigned N_DIGIT = 6
);
    logic [7*N_DIGIT-1:0] i_seg;
    logic [N_DIGIT-1:0]   i_dp;
    logic                 i_valid;
    logic                 o_ready;

    modport master (
        output i_seg,
        output i_dp,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_seg,
        input  i_dp,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered frame loads, per-digit
// blink and a blanking dead-time at the start of every digit slot.
module fnd_scan_ctrl #(
    parameter int unsigned N_DIGIT     = 6,
    parameter int unsigned SCAN_DIV    = 5000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter bit          ENB_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    fnd_scan_ctrl_if.slave     load,
    input  logic [N_DIGIT-1:0] i_blink_mask,
    output logic [6:0]         o_seg,
    output logic               o_seg_dp,
    output logic [N_DIGIT-1:0] o_seg_enb,
    output logic               o_frame_done
);

    localparam int unsigned SLOT_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned DIG_W   = (N_DIGIT   > 1) ? $clog2(N_DIGIT)   : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [N_DIGIT-1:0] ENB_OFF = ENB_ACT_LOW ? {N_DIGIT{1'b1}} : {N_DIGIT{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    localparam slot_state_t ST_RESET = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

    // Counters and slot phase
    logic [SLOT_W-1:0]  slot_cnt, slot_nxt;
    logic [DIG_W-1:0]   digit, digit_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
    logic               blink_ph, blink_ph_nxt;
    slot_state_t        state, state_nxt;

    // Frame buffers; ready doubles as "pending buffer empty"
    logic [N_DIGIT-1:0][6:0] seg_in;
    logic [N_DIGIT-1:0][6:0] active_seg, active_seg_nxt;
    logic [N_DIGIT-1:0][6:0] pend_seg, pend_seg_nxt;
    logic [N_DIGIT-1:0]      active_dp, active_dp_nxt;
    logic [N_DIGIT-1:0]      pend_dp, pend_dp_nxt;
    logic                    ready, ready_nxt;

    // Registered output next values
    logic [6:0]         seg_nxt;
    logic               dp_nxt;
    logic [N_DIGIT-1:0] enb_on;
    logic [N_DIGIT-1:0] enb_nxt;

    logic slot_wrap;
    logic digit_last;
    logic frame_end;
    logic blink_wrap;
    logic blinked;

    assign seg_in = load.i_seg;
    assign load.o_ready = ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt     <= '0;
            digit        <= '0;
            blink_cnt    <= '0;
            blink_ph     <= 1'b0;
            state        <= ST_RESET;
            active_seg   <= '0;
            active_dp    <= '0;
            pend_seg     <= '0;
            pend_dp      <= '0;
            ready        <= 1'b1;
            o_seg        <= '0;
            o_seg_dp     <= 1'b0;
            o_seg_enb    <= ENB_OFF;
            o_frame_done <= 1'b0;
        end else begin
            slot_cnt     <= slot_nxt;
            digit        <= digit_nxt;
            blink_cnt    <= blink_cnt_nxt;
            blink_ph     <= blink_ph_nxt;
            state        <= state_nxt;
            active_seg   <= active_seg_nxt;
            active_dp    <= active_dp_nxt;
            pend_seg     <= pend_seg_nxt;
            pend_dp      <= pend_dp_nxt;
            ready        <= ready_nxt;
            o_seg        <= seg_nxt;
            o_seg_dp     <= dp_nxt;
            o_seg_enb    <= enb_nxt;
            o_frame_done <= frame_end;
        end
    end

    // Next state and outputs
    always_comb begin
        slot_nxt       = slot_cnt;
        digit_nxt      = digit;
        blink_cnt_nxt  = blink_cnt;
        blink_ph_nxt   = blink_ph;
        state_nxt      = state;
        active_seg_nxt = active_seg;
        active_dp_nxt  = active_dp;
        pend_seg_nxt   = pend_seg;
        pend_dp_nxt    = pend_dp;
        ready_nxt      = ready;
        seg_nxt        = '0;
        dp_nxt         = 1'b0;
        enb_on         = '0;

        slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
        digit_last = (digit == DIG_W'(N_DIGIT - 1));
        frame_end  = slot_wrap && digit_last;
        blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
        blinked    = blink_ph && i_blink_mask[digit];

        slot_nxt = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
        if (slot_wrap) begin
            digit_nxt = digit_last ? '0 : digit + DIG_W'(1);
        end

        blink_cnt_nxt = blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
        if (blink_wrap) begin
            blink_ph_nxt = ~blink_ph;
        end

        // Phase tracks the slot_cnt value about to be loaded
        state_nxt = (slot_nxt < SLOT_W'(BLANK_CYC)) ? ST_BLANK : ST_DRIVE;

        // Pending frame is promoted only at the frame boundary, keeping frames tear-free
        if (frame_end && !ready) begin
            active_seg_nxt = pend_seg;
            active_dp_nxt  = pend_dp;
            ready_nxt      = 1'b1;
        end else if (load.i_valid && ready) begin
            pend_seg_nxt = seg_in;
            pend_dp_nxt  = load.i_dp;
            ready_nxt    = 1'b0;
        end

        case (state)
            ST_DRIVE: begin
                if (!blinked) begin
                    enb_on[digit] = 1'b1;
                    seg_nxt       = active_seg[digit];
                    dp_nxt        = active_dp[digit];
                end
            end
            default: begin
            end
        endcase

        enb_nxt = ENB_ACT_LOW ? ~enb_on : enb_on;
    end

endmodule
